// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem
// Memory-access stage of the five-stage MIPS pipeline. It takes the operator,
// operands and write-back fields registered by EX/MEM. It performs big-endian
// byte/half/word loads and stores over a request/acknowledge data-RAM port.
// It stalls the upper pipeline while an access is outstanding. It also drives
// the write-back fields that MEM/WB captures.
//
// Ports
//   clock, reset             pipeline clock (rising edge), async active-low reset
//   mem_instruction          instruction word, [15:0] is the load/store offset
//   mem_operator             operator code (memory ops listed below)
//   mem_operand_a / _b       base address / store data
//   mem_reg_write_*          write-back fields coming from EX
//   ram_request              registered access request, held until ack/timeout
//   ram_write_enable         1 = store
//   ram_address              word-aligned address
//   ram_byte_select          byte lanes, bit 3 = bits [31:24]
//   ram_write_data           lane-replicated store data
//   ram_read_data, ram_ack   read data and one-cycle completion pulse
//   stall_request            holds the pipeline at and above EX/MEM
//   wb_reg_write_*           write-back fields to MEM/WB
//   address_error            misaligned access (meaningful in IDLE only)
//   bus_error                access aborted by timeout, asserted during DONE
// ---------------------------------------------------------------------------
module stage_mem #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_instruction,
    input  logic [7:0]  mem_operator,
    input  logic [31:0] mem_operand_a,
    input  logic [31:0] mem_operand_b,
    input  logic        mem_reg_write_enable,
    input  logic [4:0]  mem_reg_write_address,
    input  logic [31:0] mem_reg_write_data,
    output logic        ram_request,
    output logic        ram_write_enable,
    output logic [31:0] ram_address,
    output logic [3:0]  ram_byte_select,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ack,
    output logic        stall_request,
    output logic        wb_reg_write_enable,
    output logic [4:0]  wb_reg_write_address,
    output logic [31:0] wb_reg_write_data,
    output logic        address_error,
    output logic        bus_error
);

    // Memory operator codes shared with the rest of the pipeline.
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    // The counter must be able to hold TIMEOUT_CYCLES - 1.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'd0,
        SIZE_BYTE = 2'd1,
        SIZE_HALF = 2'd2,
        SIZE_WORD = 2'd3
    } size_t;

    function automatic size_t op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
            OP_LW, OP_SW:         op_size = SIZE_WORD;
            default:              op_size = SIZE_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [7:0] op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_signed(input logic [7:0] op);
        op_is_signed = (op == OP_LB) || (op == OP_LH);
    endfunction

    state_t          state;
    logic [CW-1:0]   count;
    logic            bus_error_flag;
    size_t           size_q;
    logic            load_q;
    logic            sign_q;
    logic [1:0]      offset_q;
    logic [31:0]     read_data_q;

    size_t           size;
    logic            is_mem;
    logic            is_store;
    logic            misaligned;
    logic            mem_go;
    logic [31:0]     ea;
    logic [3:0]      lane_select;
    logic [31:0]     store_data;

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [31:0]     load_data;

    // Only the low half of the instruction carries the offset.
    logic            unused_upper;
    assign unused_upper = ^mem_instruction[31:16];

    assign ea = mem_operand_a + {{16{mem_instruction[15]}}, mem_instruction[15:0]};

    // Decode the incoming operator. Compute the alignment, the byte lanes and
    // the lane-replicated store data. Big-endian: ea[1:0] = 0 is bits [31:24].
    always_comb begin
        size        = op_size(mem_operator);
        is_mem      = (size != SIZE_NONE);
        is_store    = op_is_store(mem_operator);
        misaligned  = 1'b0;
        lane_select = 4'b0000;
        store_data  = mem_operand_b;
        case (size)
            SIZE_BYTE: begin
                lane_select = 4'b1000 >> ea[1:0];
                store_data  = {4{mem_operand_b[7:0]}};
            end
            SIZE_HALF: begin
                misaligned  = ea[0];
                lane_select = ea[1] ? 4'b0011 : 4'b1100;
                store_data  = {2{mem_operand_b[15:0]}};
            end
            SIZE_WORD: begin
                misaligned  = (ea[1:0] != 2'b00);
                lane_select = 4'b1111;
            end
            default: ;
        endcase
        mem_go = is_mem && !misaligned;
    end

    // Access sequencer. IDLE latches the bus fields of an aligned memory op.
    // BUSY holds the request until ack or timeout. DONE presents the result
    // for one cycle. bus_error_flag clears on the way back through IDLE, so
    // it covers the whole DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            count            <= '0;
            bus_error_flag   <= 1'b0;
            size_q           <= SIZE_NONE;
            load_q           <= 1'b0;
            sign_q           <= 1'b0;
            offset_q         <= 2'b00;
            read_data_q      <= 32'h0;
            ram_request      <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_address      <= 32'h0;
            ram_byte_select  <= 4'b0000;
            ram_write_data   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    count          <= '0;
                    bus_error_flag <= 1'b0;
                    if (mem_go) begin
                        ram_request      <= 1'b1;
                        ram_write_enable <= is_store;
                        ram_address      <= {ea[31:2], 2'b00};
                        ram_byte_select  <= lane_select;
                        ram_write_data   <= store_data;
                        size_q           <= size;
                        load_q           <= !is_store;
                        sign_q           <= op_is_signed(mem_operator);
                        offset_q         <= ea[1:0];
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (ram_ack) begin
                        read_data_q <= ram_read_data;
                        ram_request <= 1'b0;
                        state       <= DONE;
                    end else if (count == LAST_COUNT) begin
                        bus_error_flag <= 1'b1;
                        ram_request    <= 1'b0;
                        state          <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    ram_request <= 1'b0;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the captured word and extend it.
    always_comb begin
        case (offset_q)
            2'd0:    load_byte = read_data_q[31:24];
            2'd1:    load_byte = read_data_q[23:16];
            2'd2:    load_byte = read_data_q[15:8];
            default: load_byte = read_data_q[7:0];
        endcase
        load_half = offset_q[1] ? read_data_q[15:0] : read_data_q[31:16];
        case (size_q)
            SIZE_BYTE: load_data = sign_q ? {{24{load_byte[7]}}, load_byte}
                                          : {24'h0, load_byte};
            SIZE_HALF: load_data = sign_q ? {{16{load_half[15]}}, load_half}
                                          : {16'h0, load_half};
            default:   load_data = read_data_q;
        endcase
    end

    // Pipeline-facing outputs. Non-memory ops flow straight through. Memory
    // ops write back only a successful load, and only in DONE.
    always_comb begin
        stall_request        = ((state == IDLE) && mem_go) || (state == BUSY);
        address_error        = (state == IDLE) && is_mem && misaligned;
        bus_error            = (state == DONE) && bus_error_flag;
        wb_reg_write_address = mem_reg_write_address;
        wb_reg_write_enable  = mem_reg_write_enable;
        wb_reg_write_data    = mem_reg_write_data;
        if (is_mem) begin
            wb_reg_write_enable = (state == DONE) && load_q && !bus_error_flag;
            wb_reg_write_data   = wb_reg_write_enable ? load_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// ---------------------------------------------------------------------------
// tb_stage_mem
// Scoreboard bench for stage_mem (built with TIMEOUT_CYCLES = 4). The driver
// presents one EX/MEM op at a time. It pushes the expected write-back and bus
// request, then waits for the pipeline to advance. A monitor compares each
// bus request as it rises, and compares the write-back fields on the cycle
// the op leaves the stage. A small RAM model acks after a programmable delay,
// or stays silent.
// ---------------------------------------------------------------------------
module tb_stage_mem;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        check_data;
        logic        berr;
        logic        aerr;
        int          stalls;
        int          reqs;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_instruction;
    logic [7:0]  mem_operator;
    logic [31:0] mem_operand_a;
    logic [31:0] mem_operand_b;
    logic        mem_reg_write_enable;
    logic [4:0]  mem_reg_write_address;
    logic [31:0] mem_reg_write_data;
    logic        ram_request;
    logic        ram_write_enable;
    logic [31:0] ram_address;
    logic [3:0]  ram_byte_select;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ack;
    logic        stall_request;
    logic        wb_reg_write_enable;
    logic [4:0]  wb_reg_write_address;
    logic [31:0] wb_reg_write_data;
    logic        address_error;
    logic        bus_error;

    wb_exp_t     wb_q[$];
    bus_exp_t    bus_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        issue_valid;

    int          ram_delay;
    logic        ram_silent;
    logic [31:0] ram_data;

    stage_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .mem_instruction       (mem_instruction),
        .mem_operator          (mem_operator),
        .mem_operand_a         (mem_operand_a),
        .mem_operand_b         (mem_operand_b),
        .mem_reg_write_enable  (mem_reg_write_enable),
        .mem_reg_write_address (mem_reg_write_address),
        .mem_reg_write_data    (mem_reg_write_data),
        .ram_request           (ram_request),
        .ram_write_enable      (ram_write_enable),
        .ram_address           (ram_address),
        .ram_byte_select       (ram_byte_select),
        .ram_write_data        (ram_write_data),
        .ram_read_data         (ram_read_data),
        .ram_ack               (ram_ack),
        .stall_request         (stall_request),
        .wb_reg_write_enable   (wb_reg_write_enable),
        .wb_reg_write_address  (wb_reg_write_address),
        .wb_reg_write_data     (wb_reg_write_data),
        .address_error         (address_error),
        .bus_error             (bus_error)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic push_wb(input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic check_data,
                           input logic berr, input logic aerr,
                           input int stalls, input int reqs);
        wb_exp_t e;
        e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.check_data = check_data;
        e.berr = berr; e.aerr = aerr; e.stalls = stalls; e.reqs = reqs;
        wb_q.push_back(e);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic [3:0] sel,
                            input logic we, input logic [31:0] wdata);
        bus_exp_t e;
        e.addr = addr; e.sel = sel; e.we = we; e.wdata = wdata;
        bus_q.push_back(e);
    endtask

    task automatic set_inputs(input logic [7:0] op, input logic [15:0] offset,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic wen, input logic [31:0] wdata,
                              input logic [4:0] waddr);
        mem_operator          = op;
        mem_instruction       = {16'hABCD, offset};
        mem_operand_a         = a;
        mem_operand_b         = b;
        mem_reg_write_enable  = wen;
        mem_reg_write_data    = wdata;
        mem_reg_write_address = waddr;
        issue_valid           = 1'b1;
    endtask

    // Waits until the stage lets EX/MEM advance, then steps past that edge.
    task automatic wait_advance();
        bit advanced = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!stall_request) begin
                advanced = 1;
                break;
            end
        end
        if (!advanced) begin
            checks++;
            errors++;
            $display("[TB] FAIL advance_timeout: got stall held 40 cycles, expected release");
        end
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input logic [15:0] offset,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic wen, input logic [31:0] wdata,
                                  input logic [4:0] waddr);
        set_inputs(op, offset, a, b, wen, wdata, waddr);
        wait_advance();
    endtask

    // RAM model: acks ram_delay BUSY cycles after the request rises.
    initial begin
        int cnt = 0;
        ram_ack       = 1'b0;
        ram_read_data = 32'h5555_5555;
        forever begin
            @(negedge clock);
            ram_ack       = 1'b0;
            ram_read_data = 32'h5555_5555;
            if (!ram_request) begin
                cnt = 0;
            end else if (!ram_silent) begin
                if (cnt == ram_delay) begin
                    ram_ack       = 1'b1;
                    ram_read_data = ram_data;
                end
                cnt++;
            end
        end
    end

    // Monitor: compares the bus fields when a request rises, and compares the
    // write-back fields on the cycle an op leaves the stage.
    initial begin
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        logic prev_req  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stall_cnt = 0;
                req_cnt   = 0;
                prev_req  = 1'b0;
            end else begin
                if (ram_request) begin
                    req_cnt++;
                    if (!prev_req) begin
                        if (bus_q.size() == 0) begin
                            check_output("bus_unexpected_request", 32'd1, 32'd0);
                        end else begin
                            bus_exp_t b;
                            b = bus_q.pop_front();
                            check_output("bus_addr", ram_address, b.addr);
                            check_output("bus_sel", {28'h0, ram_byte_select}, {28'h0, b.sel});
                            check_output("bus_we", {31'h0, ram_write_enable}, {31'h0, b.we});
                            if (b.we)
                                check_output("bus_wdata", ram_write_data, b.wdata);
                        end
                    end
                end
                prev_req = ram_request;
                if (issue_valid) begin
                    if (stall_request) begin
                        stall_cnt++;
                    end else begin
                        if (wb_q.size() == 0) begin
                            check_output("wb_unexpected_advance", 32'd1, 32'd0);
                        end else begin
                            wb_exp_t e;
                            e = wb_q.pop_front();
                            check_output("wb_enable", {31'h0, wb_reg_write_enable}, {31'h0, e.wen});
                            check_output("wb_address", {27'h0, wb_reg_write_address}, {27'h0, e.waddr});
                            if (e.check_data)
                                check_output("wb_data", wb_reg_write_data, e.wdata);
                            check_output("bus_error", {31'h0, bus_error}, {31'h0, e.berr});
                            check_output("address_error", {31'h0, address_error}, {31'h0, e.aerr});
                            check_output("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                            check_output("request_cycles", 32'(req_cnt), 32'(e.reqs));
                        end
                        stall_cnt = 0;
                        req_cnt   = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b0;
        ram_delay   = 0;
        ram_silent  = 1'b0;
        ram_data    = 32'h0;
        set_inputs(OP_NOP, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
        issue_valid = 1'b0;

        // Reset state of the registered bus side.
        #12;
        check_output("reset_request", {31'h0, ram_request}, 32'h0);
        check_output("reset_write_enable", {31'h0, ram_write_enable}, 32'h0);
        check_output("reset_address", ram_address, 32'h0);
        check_output("reset_select", {28'h0, ram_byte_select}, 32'h0);
        check_output("reset_write_data", ram_write_data, 32'h0);
        check_output("reset_bus_error", {31'h0, bus_error}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] non-memory pass-through");
        push_wb(1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 0, 0);
        apply_stimulus(OP_NOP, 16'h0, 32'h100, 32'h0, 1'b1, 32'h1234_5678, 5'd3);

        $display("[TB] LB / LBU at 0x103");
        ram_delay = 0; ram_data = 32'h0000_0080;
        push_bus(32'h100, 4'b0001, 1'b0, 32'h0);
        push_wb(1'b1, 5'd4, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_LB, 16'h0003, 32'h100, 32'h0, 1'b1, 32'h0, 5'd4);
        push_bus(32'h100, 4'b0001, 1'b0, 32'h0);
        push_wb(1'b1, 5'd5, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_LBU, 16'h0003, 32'h100, 32'h0, 1'b1, 32'h0, 5'd5);

        $display("[TB] SH at 0x202");
        push_bus(32'h200, 4'b0011, 1'b1, 32'hBEEF_BEEF);
        push_wb(1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_SH, 16'h0002, 32'h200, 32'hAAAA_BEEF, 1'b1, 32'h0, 5'd6);

        $display("[TB] misaligned LW at 0x101");
        push_wb(1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        apply_stimulus(OP_LW, 16'h0001, 32'h100, 32'h0, 1'b1, 32'h0, 5'd7);

        $display("[TB] LH at 0x102 with negative offset, LHU at 0x100");
        ram_data = 32'h1234_8001;
        push_bus(32'h100, 4'b0011, 1'b0, 32'h0);
        push_wb(1'b1, 5'd8, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_LH, 16'hFFF2, 32'h110, 32'h0, 1'b1, 32'h0, 5'd8);
        ram_data = 32'h8001_1234;
        push_bus(32'h100, 4'b1100, 1'b0, 32'h0);
        push_wb(1'b1, 5'd9, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_LHU, 16'h0000, 32'h100, 32'h0, 1'b1, 32'h0, 5'd9);

        $display("[TB] SB at 0x301");
        push_bus(32'h300, 4'b0100, 1'b1, 32'h5A5A_5A5A);
        push_wb(1'b0, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        apply_stimulus(OP_SB, 16'h0001, 32'h300, 32'h1234_565A, 1'b1, 32'h0, 5'd10);

        $display("[TB] LW with ack in last allowed BUSY cycle");
        ram_delay = 3; ram_data = 32'hDEAD_BEEF;
        push_bus(32'h404, 4'b1111, 1'b0, 32'h0);
        push_wb(1'b1, 5'd11, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5, 4);
        apply_stimulus(OP_LW, 16'h0004, 32'h400, 32'h0, 1'b1, 32'h0, 5'd11);

        $display("[TB] SW timeout");
        ram_silent = 1'b1;
        push_bus(32'h500, 4'b1111, 1'b1, 32'hCAFE_F00D);
        push_wb(1'b0, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 5, 4);
        apply_stimulus(OP_SW, 16'h0000, 32'h500, 32'hCAFE_F00D, 1'b1, 32'h0, 5'd12);
        ram_silent = 1'b0;

        $display("[TB] LBU right after the aborted access");
        ram_delay = 1; ram_data = 32'hAB00_0000;
        push_bus(32'h600, 4'b1000, 1'b0, 32'h0);
        push_wb(1'b1, 5'd13, 32'h0000_00AB, 1'b1, 1'b0, 1'b0, 3, 2);
        apply_stimulus(OP_LBU, 16'h0000, 32'h600, 32'h0, 1'b1, 32'h0, 5'd13);

        $display("[TB] reset during second BUSY cycle");
        ram_delay = 2; ram_data = 32'h1111_2222;
        push_bus(32'h700, 4'b1111, 1'b0, 32'h0);
        push_bus(32'h700, 4'b1111, 1'b0, 32'h0);
        push_wb(1'b1, 5'd14, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 4, 3);
        set_inputs(OP_LW, 16'h0000, 32'h700, 32'h0, 1'b1, 32'h0, 5'd14);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("midreset_request", {31'h0, ram_request}, 32'h0);
        check_output("midreset_address", ram_address, 32'h0);
        check_output("midreset_select", {28'h0, ram_byte_select}, 32'h0);
        check_output("midreset_stall", {31'h0, stall_request}, 32'h1);
        @(posedge clock);
        #1 reset = 1'b1;
        wait_advance();

        $display("[TB] misaligned SH at 0x203, then non-memory op with enable 0");
        push_wb(1'b0, 5'd15, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        apply_stimulus(OP_SH, 16'h0003, 32'h200, 32'h0, 1'b1, 32'h0, 5'd15);
        push_wb(1'b0, 5'd16, 32'h0000_FACE, 1'b1, 1'b0, 1'b0, 0, 0);
        apply_stimulus(OP_NOP, 16'h0000, 32'h0, 32'h0, 1'b0, 32'h0000_FACE, 5'd16);

        @(negedge clock);
        check_output("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check_output("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
